// File: rtl/jtag_master_pkg.sv
// -----------------------------------------------------------------------------
// jtag_master_pkg
// Shared definitions for the JTAG master sequencer: opcodes, FSM state
// encoding and the fixed TAP-reset TMS pattern.
// -----------------------------------------------------------------------------
package jtag_master_pkg;

   localparam logic [1:0] OP_RESET     = 2'd0;
   localparam logic [1:0] OP_TMS_SEQ   = 2'd1;
   localparam logic [1:0] OP_SCAN      = 2'd2;
   localparam logic [1:0] OP_SCAN_FLIP = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_TCK_LO = 3'd2,
      ST_TCK_HI = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   // Five TMS=1 clocks reach Test-Logic-Reset from any state, the trailing
   // 0 parks the TAP in Run-Test/Idle. LSB is shifted first.
   localparam logic [5:0] RESET_TMS_PATTERN = 6'b011111;
   localparam int         RESET_LEN         = 6;

endpackage

// File: rtl/jtag_tck_div.sv
// -----------------------------------------------------------------------------
// jtag_tck_div
// Half-period counter for TCK generation. While i_en is high it emits a
// one-cycle o_phase_done pulse every HALF_DIV mclk cycles; while i_en is low
// the count is held at zero so the first phase after enabling is full length.
//
// Ports:
//   mclk          system clock
//   reset_n       asynchronous active-low reset
//   i_en          count enable / load (low reloads the counter)
//   o_phase_done  high during the last mclk cycle of each half period
// -----------------------------------------------------------------------------
module jtag_tck_div #(
   parameter int HALF_DIV = 4
) (
   input  logic mclk,
   input  logic reset_n,
   input  logic i_en,
   output logic o_phase_done
);

   localparam int            CW   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign o_phase_done = i_en && (r_cnt == LAST);

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n)                   r_cnt <= '0;
      else if (!i_en || r_cnt == LAST) r_cnt <= '0;
      else                            r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/jtag_master_ctrl.sv
// -----------------------------------------------------------------------------
// jtag_master_ctrl
// Command-driven JTAG TAP sequencer. One command (RESET, TMS_SEQ, SCAN,
// SCAN_FLIP) is expanded into TCK/TMS/TDI on a divided clock; TDO is captured
// at the end of each high phase and returned as one response per command.
//
// Ports:
//   mclk, reset_n          system clock, async active-low reset
//   enable                 gates cmd_ready (in-flight commands still finish)
//   cmd_valid/cmd_ready    command handshake
//   cmd_op, cmd_len        opcode and bit count (clamped to MAX_BITS)
//   cmd_tms, cmd_tdi       per-bit TMS / TDI data, LSB first
//   rsp_valid/rsp_ready    response handshake
//   rsp_tdo                captured TDO, LSB = first bit
//   busy                   command accepted, response not yet taken
//   tck, tms, tdi, tdo     JTAG pins (tdo is asynchronous)
// -----------------------------------------------------------------------------
import jtag_master_pkg::*;

module jtag_master_ctrl #(
   parameter int HALF_DIV = 4,
   parameter int MAX_BITS = 32
) (
   input  logic                mclk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [5:0]          cmd_len,
   input  logic [MAX_BITS-1:0] cmd_tms,
   input  logic [MAX_BITS-1:0] cmd_tdi,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [MAX_BITS-1:0] rsp_tdo,
   output logic                busy,
   output logic                tck,
   output logic                tms,
   output logic                tdi,
   input  logic                tdo
);

   localparam int LEN_W = $clog2(MAX_BITS + 1);

   state_t              r_state;
   logic                r_flip;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_bit;
   logic [MAX_BITS-1:0] r_tms_sh;
   logic [MAX_BITS-1:0] r_tdi_sh;
   logic [MAX_BITS-1:0] r_cap;
   logic [MAX_BITS-1:0] r_mask;
   logic                r_tck;
   logic                r_tms;
   logic                r_tdi;
   logic                r_rsp_valid;
   logic                r_busy;
   logic                r_tdo_s1;
   logic                r_tdo_s2;

   logic [LEN_W-1:0]    w_len;
   logic [LEN_W-1:0]    w_bit_nxt;
   logic [LEN_W-1:0]    w_bit_nxt2;
   logic                w_div_en;
   logic                w_phase_done;
   logic                w_cmd_ready;

   // reset_n is folded in so cmd_ready reads 0 for the whole reset pulse
   assign w_cmd_ready = reset_n && enable && (r_state == ST_IDLE);
   assign w_div_en    = (r_state == ST_TCK_LO) || (r_state == ST_TCK_HI);
   assign w_bit_nxt   = r_bit + LEN_W'(1);
   assign w_bit_nxt2  = r_bit + LEN_W'(2);

   always_comb begin
      w_len = LEN_W'(cmd_len);
      if (cmd_op == OP_RESET)             w_len = LEN_W'(RESET_LEN);
      else if (int'(cmd_len) > MAX_BITS)  w_len = LEN_W'(MAX_BITS);
   end

   jtag_tck_div #(.HALF_DIV(HALF_DIV)) u_div (
      .mclk         (mclk),
      .reset_n      (reset_n),
      .i_en         (w_div_en),
      .o_phase_done (w_phase_done)
   );

   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         r_tdo_s1 <= 1'b0;
         r_tdo_s2 <= 1'b0;
      end else begin
         r_tdo_s1 <= tdo;
         r_tdo_s2 <= r_tdo_s1;
      end
   end

   // TMS/TDI data are held in right-shifting registers so bit 0 is always
   // the current bit and bit 1 the next one. Capture uses a walking one-hot
   // mask, which leaves bits at and above len at zero.
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_flip      <= 1'b0;
         r_len       <= '0;
         r_bit       <= '0;
         r_tms_sh    <= '0;
         r_tdi_sh    <= '0;
         r_cap       <= '0;
         r_mask      <= '0;
         r_tck       <= 1'b0;
         r_tms       <= 1'b0;
         r_tdi       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid && w_cmd_ready) begin
                  r_flip   <= (cmd_op == OP_SCAN_FLIP);
                  r_len    <= w_len;
                  r_bit    <= '0;
                  r_cap    <= '0;
                  r_mask   <= MAX_BITS'(1);
                  r_busy   <= 1'b1;
                  case (cmd_op)
                     OP_RESET:   r_tms_sh <= MAX_BITS'(RESET_TMS_PATTERN);
                     OP_TMS_SEQ: r_tms_sh <= cmd_tms;
                     default:    r_tms_sh <= '0;
                  endcase
                  r_tdi_sh <= (cmd_op == OP_SCAN || cmd_op == OP_SCAN_FLIP) ? cmd_tdi : '0;
                  r_state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (r_len == '0) begin
                  r_tms   <= 1'b0;
                  r_tdi   <= 1'b0;
                  r_state <= ST_RESP;
               end else begin
                  r_tms   <= r_flip ? (r_len == LEN_W'(1)) : r_tms_sh[0];
                  r_tdi   <= r_tdi_sh[0];
                  r_state <= ST_TCK_LO;
               end
            end
            ST_TCK_LO: begin
               if (w_phase_done) begin
                  r_tck   <= 1'b1;
                  r_state <= ST_TCK_HI;
               end
            end
            ST_TCK_HI: begin
               if (w_phase_done) begin
                  r_tck    <= 1'b0;
                  r_cap    <= r_cap | (r_tdo_s2 ? r_mask : '0);
                  r_mask   <= r_mask << 1;
                  r_bit    <= w_bit_nxt;
                  r_tms_sh <= r_tms_sh >> 1;
                  r_tdi_sh <= r_tdi_sh >> 1;
                  if (w_bit_nxt == r_len) begin
                     r_tms   <= 1'b0;
                     r_tdi   <= 1'b0;
                     r_state <= ST_RESP;
                  end else begin
                     r_tms   <= r_flip ? (w_bit_nxt2 == r_len) : r_tms_sh[1];
                     r_tdi   <= r_tdi_sh[1];
                     r_state <= ST_TCK_LO;
                  end
               end
            end
            ST_RESP: begin
               // rsp_valid rises one cycle after entering RESP
               if (r_rsp_valid && rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_rsp_valid <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = w_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_tdo   = r_cap;
   assign busy      = r_busy;
   assign tck       = r_tck;
   assign tms       = r_tms;
   assign tdi       = r_tdi;

endmodule

// File: tb/tb_jtag_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_jtag_master_ctrl
// Scoreboard bench: the driver pushes the expected per-command waveform and
// response into a queue; a monitor records TMS/TDI at every TCK rise and pops
// and compares when rsp_valid rises. The TAP is modelled as a one-bit
// tdi->tdo loopback (capture on TCK rise, update on TCK fall).
// -----------------------------------------------------------------------------
module tb_jtag_master_ctrl;

   localparam int HALF = 4;
   localparam int MAXB = 32;
   localparam int PER  = 10;

   logic            mclk = 1'b0;
   logic            reset_n, enable, cmd_valid, rsp_ready;
   logic [1:0]      cmd_op;
   logic [5:0]      cmd_len;
   logic [MAXB-1:0] cmd_tms, cmd_tdi;
   logic            cmd_ready, rsp_valid, busy, tck, tms, tdi;
   logic [MAXB-1:0] rsp_tdo;
   logic            tdo = 1'b0;
   logic            tap_q = 1'b0;
   logic            tap_clr = 1'b0;

   jtag_master_ctrl #(.HALF_DIV(HALF), .MAX_BITS(MAXB)) dut (
      .mclk(mclk), .reset_n(reset_n), .enable(enable),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
      .busy(busy), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
   );

   always #(PER/2) mclk = ~mclk;

   // loopback TAP: tdo during bit k carries tdi of bit k-1
   always @(posedge tck or negedge tck or posedge tap_clr) begin
      if (tap_clr) begin tap_q = 1'b0; tdo = 1'b0; end
      else if (tck) tap_q = tdi;
      else          tdo = tap_q;
   end

   typedef struct {
      int          len;
      logic [63:0] tms;
      logic [63:0] tdi;
      logic [63:0] tdo;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: per-bit waveform straight from the opcode rules
   function automatic exp_t model(input logic [1:0] op, input logic [5:0] len,
                                  input logic [31:0] tv, input logic [31:0] dv);
      exp_t e;
      int   n;
      logic mb, db;
      n = (op == 2'd0) ? 6 : ((int'(len) > MAXB) ? MAXB : int'(len));
      e.len = n; e.tms = '0; e.tdi = '0; e.tdo = '0;
      for (int k = 0; k < n; k++) begin
         case (op)
            2'd0:    begin mb = (k < 5);    db = 1'b0;  end
            2'd1:    begin mb = tv[k];      db = 1'b0;  end
            2'd2:    begin mb = 1'b0;       db = dv[k]; end
            default: begin mb = (k == n-1); db = dv[k]; end
         endcase
         e.tms[k] = mb;
         e.tdi[k] = db;
         if (k > 0) e.tdo[k] = e.tdi[k-1];
      end
      e.lat = 2 + 2*HALF*n;
      return e;
   endfunction

   // ---------------- monitor ----------------
   int          mon_rise = 0;
   logic [63:0] mon_tms = '0, mon_tdi = '0;
   logic        prev_tck = 1'b0, prev_rv = 1'b0;
   time         t_acc = 0;
   logic [63:0] last_tdo = '0, last_tms = '0;
   int          last_lat = 0, last_rise = 0;

   always @(negedge mclk) begin
      if (!reset_n) begin
         mon_rise = 0; mon_tms = '0; mon_tdi = '0;
         prev_tck = 1'b0; prev_rv = 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) t_acc = $time;
         if (tck && !prev_tck) begin
            if (mon_rise < 64) begin
               mon_tms = mon_tms | (64'(tms) << mon_rise);
               mon_tdi = mon_tdi | (64'(tdi) << mon_rise);
            end
            mon_rise++;
         end
         if (rsp_valid && !prev_rv) begin
            last_lat  = int'(($time - t_acc) / PER) - 1;
            last_rise = mon_rise;
            last_tdo  = 64'(rsp_tdo);
            last_tms  = mon_tms;
            if (sb.size() == 0) chk("sb_unexpected_rsp", 64'd1, 64'd0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("tck_rises", 64'(mon_rise), 64'(e.len));
               chk("tms_bits",  mon_tms, e.tms);
               chk("tdi_bits",  mon_tdi, e.tdi);
               chk("rsp_tdo",   64'(rsp_tdo), e.tdo);
               chk("rsp_lat",   64'(last_lat), 64'(e.lat));
            end
            mon_rise = 0; mon_tms = '0; mon_tdi = '0;
         end
         prev_tck = tck;
         prev_rv  = rsp_valid;
      end
   end

   // ---------------- driver ----------------
   task automatic start_cmd(input logic [1:0] op, input logic [5:0] len,
                            input logic [31:0] tv, input logic [31:0] dv, output bit ok);
      bit acc = 0;
      tap_clr = 1'b1; #1; tap_clr = 1'b0;
      @(posedge mclk); #1;
      cmd_op = op; cmd_len = len; cmd_tms = tv; cmd_tdi = dv; cmd_valid = 1'b1;
      sb.push_back(model(op, len, tv, dv));
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge mclk);
         if (cmd_ready) acc = 1;
         @(posedge mclk); #1;
      end
      cmd_valid = 1'b0;
      cmd_tms = $urandom; cmd_tdi = $urandom; cmd_op = 2'($urandom); cmd_len = 6'($urandom);
      if (!acc) begin
         chk("accept_timeout", 64'd1, 64'd0);
         void'(sb.pop_back());
      end
      ok = acc;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [5:0] len,
                          input logic [31:0] tv, input logic [31:0] dv,
                          input int hold, input bit poke);
      bit ok, got = 0;
      start_cmd(op, len, tv, dv, ok);
      if (!ok) return;
      if (poke) begin enable = 1'b0; cmd_valid = 1'b1; end
      for (int i = 0; i < 5000 && !got; i++) begin
         @(negedge mclk);
         if (rsp_valid) got = 1;
         else if (i < 3) begin
            chk("busy_flag", 64'(busy), 64'd1);
            if (poke) chk("ready_while_busy", 64'(cmd_ready), 64'd0);
         end
      end
      cmd_valid = 1'b0;
      enable    = 1'b1;
      if (!got) begin chk("rsp_timeout", 64'd1, 64'd0); return; end
      for (int h = 0; h < hold; h++) begin
         @(negedge mclk);
         chk("rsp_held",      64'(rsp_valid), 64'd1);
         chk("resp_tck_low",  64'(tck),       64'd0);
         chk("resp_tms_tdi",  64'({tms, tdi}), 64'd0);
         chk("resp_no_ready", 64'(cmd_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge mclk); #1;
      rsp_ready = 1'b0;
      @(negedge mclk);
      chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_busy",      64'(busy),      64'd0);
      chk("post_ready",     64'(cmd_ready), 64'd1);
   endtask

   initial begin
      bit ok, seen;
      reset_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = '0; cmd_len = '0; cmd_tms = '0; cmd_tdi = '0;
      #12;
      chk("rst_tck",       64'(tck),       64'd0);
      chk("rst_tms",       64'(tms),       64'd0);
      chk("rst_tdi",       64'(tdi),       64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_rsp_tdo",   64'(rsp_tdo),   64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      #10 reset_n = 1'b1;

      // directed cases
      run_cmd(2'd0, 6'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("reset_lat50", 64'(last_lat), 64'd50);
      chk("reset_tdo0",  last_tdo, 64'd0);
      run_cmd(2'd2, 6'd8, 32'hFFFF_FFFF, 32'h0000_00A5, 1, 0);
      chk("scan_a5_tdo", last_tdo, 64'h4A);
      run_cmd(2'd3, 6'd32, 32'h0, 32'hDEAD_BEEF, 0, 0);
      chk("flip_tms_bit31", last_tms, 64'h8000_0000);
      run_cmd(2'd1, 6'd5, 32'h0000_0003, 32'hFFFF_FFFF, 0, 0);
      chk("tms_seq_bits", last_tms, 64'h03);
      run_cmd(2'd2, 6'd0, 32'h0, 32'hFFFF_FFFF, 0, 0);
      chk("len0_lat",   64'(last_lat),  64'd2);
      chk("len0_rises", 64'(last_rise), 64'd0);
      run_cmd(2'd3, 6'd40, 32'h0, 32'h1234_5678, 0, 0);
      chk("len40_clamp", 64'(last_rise), 64'd32);
      run_cmd(2'd3, 6'd1, 32'h0, 32'h1, 0, 0);
      chk("flip_len1_tms", last_tms, 64'h1);

      // reset during bit 10 of a scan
      start_cmd(2'd2, 6'd32, 32'h0, 32'hFFFF_FFFF, ok);
      seen = 0;
      for (int i = 0; i < 1000 && ok && !seen; i++) begin
         @(negedge mclk);
         if (mon_rise >= 11) seen = 1;
      end
      chk("reach_bit10", 64'(seen), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_tck",       64'(tck),       64'd0);
      chk("mid_rst_tms_tdi",   64'({tms, tdi}), 64'd0);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_busy",      64'(busy),      64'd0);
      chk("mid_rst_rsp_tdo",   64'(rsp_tdo),   64'd0);
      chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
      sb.delete();
      @(negedge mclk); @(negedge mclk);
      #2 reset_n = 1'b1;
      @(negedge mclk);
      chk("post_rst_idle_ready", 64'(cmd_ready), 64'd1);
      chk("post_rst_busy",       64'(busy),      64'd0);

      // rsp_ready held low for 20 cycles, enable dropped mid-command
      run_cmd(2'd2, 6'd4, 32'h0, 32'h0000_000B, 20, 1);

      // randomized traffic
      for (int n = 0; n < 30; n++) begin
         run_cmd(2'($urandom_range(0, 3)), 6'($urandom_range(0, 40)),
                 $urandom, $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge mclk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #(PER * 90000);
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

endmodule

// File: doc/jtag_master_ctrl.md
# jtag_master_ctrl

Synthesizable command-driven JTAG TAP sequencer. It replaces the behavioural testbench JTAG driver with RTL that an on-chip host, such as a Wishbone register block or a debug bridge, can drive. Each command is one of four operations: TAP reset, TMS sequence, scan chain, or scan chain with TMS flip on the last bit. The block expands the command into TCK/TMS/TDI waveforms on a divided clock, captures TDO, and returns one response per command.

## Interface
Parameters:
- HALF_DIV, 4: mclk cycles per TCK half period. Must be ≥1.
- MAX_BITS, 32: maximum bits per command. Sets the data width.

Ports:
- mclk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: when low, cmd_ready is forced low. A command already in flight completes.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: high in IDLE when enable=1.
- cmd_op, in, 2: 0=RESET, 1=TMS_SEQ, 2=SCAN, 3=SCAN_FLIP.
- cmd_len, in, 6: bit count. Values 0..MAX_BITS are used as given; larger values are clamped to MAX_BITS.
- cmd_tms, in, MAX_BITS: TMS bits, LSB first. Used by TMS_SEQ only.
- cmd_tdi, in, MAX_BITS: TDI bits, LSB first. Used by SCAN and SCAN_FLIP.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: response accepted.
- rsp_tdo, out, MAX_BITS: captured TDO, LSB = first bit. Bits at and above len are 0.
- busy, out, 1: high from command acceptance until the response is accepted.
- tck, out, 1: JTAG clock.
- tms, out, 1: JTAG mode select.
- tdi, out, 1: JTAG data in.
- tdo, in, 1: JTAG data out. Asynchronous to mclk; it is double-flopped inside the block.

## Operation
States: IDLE, SETUP, TCK_LO, TCK_HI, RESP.

- **IDLE → SETUP** on cmd_valid & cmd_ready.
  - The opcode, clamped length and data are latched.
  - The bit counter is cleared.
  - The capture register is cleared.
- **SETUP** (1 cycle): drive tms/tdi for bit 0.
- **TCK_LO** (HALF_DIV cycles): tck=0. On exit, tck goes to 1.
- **TCK_HI** (HALF_DIV cycles): tck=1.
  - On exit, tck goes to 0.
  - Synchronised tdo is stored into capture[bit].
  - The bit counter increments.
  - If the counter reached len, go to RESP.
  - Otherwise drive tms/tdi for the next bit and return to TCK_LO.
- **RESP**: rsp_valid=1 and tms=tdi=0. On rsp_ready, go to IDLE.

Per-op bit values:
- **RESET**: len is forced to 6. TMS is 1,1,1,1,1,0. tdi=0.
- **TMS_SEQ**: tms=cmd_tms[bit], tdi=0.
- **SCAN**: tdi=cmd_tdi[bit], tms=0.
- **SCAN_FLIP**: tdi=cmd_tdi[bit]. tms=1 only on bit len-1, otherwise 0.

Boundary cases:
- **len=0**: SETUP goes directly to RESP. No tck edges; rsp_tdo=0. RESET ignores len.
- **len=1 with SCAN_FLIP**: tms=1 on the single bit.
- **cmd_valid while busy**: ignored. cmd_ready=0.
- **enable falls mid-command**: the command runs to RESP normally.
- **rsp_ready held low**: RESP persists and tck stays 0.
- **Simultaneous rsp_ready and a new cmd_valid**: the new command is accepted no earlier than the cycle after returning to IDLE.
- **reset_n asserted mid-command**:
  - Immediate return to IDLE.
  - tck=0, tms=0, tdi=0, rsp_valid=0, busy=0, rsp_tdo=0.
  - The TAP state is undefined afterwards; the host issues RESET.

Reset value of every output: cmd_ready=0 while reset_n is asserted, then enable-dependent; all other outputs 0.

## Timing
- Accept edge = cycle 0. tms/tdi for bit 0 are valid from cycle 1.
- Bit k: tck rises at cycle 1+HALF_DIV+2·HALF_DIV·k and falls HALF_DIV cycles later.
- tms/tdi change only on the mclk edge where tck falls, or in SETUP, so setup and hold are HALF_DIV cycles each.
- TDO is sampled at the end of the high phase, through a 2-flop synchroniser. HALF_DIV≥2 is required when tdo is truly asynchronous.
- rsp_valid first goes high at cycle 2+2·HALF_DIV·len (len=0: cycle 2).
- TCK duty cycle is 50%. There is no free-running TCK: it toggles only in TCK_LO/TCK_HI.

## Structure
- Shared package jtag_master_pkg holds:
  - opcode localparams (OP_RESET, OP_TMS_SEQ, OP_SCAN, OP_SCAN_FLIP);
  - the state encoding;
  - RESET_TMS_PATTERN = 6'b011111 (LSB first) and RESET_LEN = 6.
- One sub-module, jtag_tck_div: the half-period counter. It has a load/enable input and emits a one-cycle `phase_done` pulse every HALF_DIV cycles.
- The top level holds the FSM, bit counter, data/capture registers and the tdo synchroniser.

## Test plan
- **RESET command**, HALF_DIV=4: exactly 6 tck rises; tms=1 on rises 1–5 and 0 on rise 6; rsp_valid at cycle 50; rsp_tdo=0.
- **SCAN**, len=8, cmd_tdi=0xA5, with the TAP model looping tdi→tdo with one bit delay: tdi pattern is LSB first; rsp_tdo=0x4A (shifted); tms stays 0.
- **SCAN_FLIP**, len=32, cmd_tdi=0xDEADBEEF, with a loopback model: tms=1 only during bit 31; rsp_tdo matches the model; 32 tck pulses.
- **TMS_SEQ**, len=5, cmd_tms=0x03: tms = 1,1,0,0,0; tdi=0; a response is returned.
- **len=0 and len=40**: len=0 gives no tck and rsp_valid at cycle 2; len=40 is clamped to 32 pulses.
- **Edge cases**:
  - reset_n pulse during bit 10 of a scan: all outputs are 0 asynchronously and the FSM is back in IDLE.
  - rsp_ready held low for 20 cycles: rsp_valid is held, tck is 0 and cmd_ready stays low.
